// File: rtl/cpu_mc.sv
// cpu_mc: multicycle 8-register CPU with a stallable, split-response memory port.
// One instruction is in flight at a time: fetch, wait for the instruction word,
// execute, then an optional memory phase for ld/st.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   o_mem_addr/rd/wr     request address and strobes, held until waitrequest=0
//   o_mem_wrdata         store data
//   i_mem_waitrequest    1 = request not accepted this cycle
//   i_mem_rddata/valid   read response, one or more cycles after acceptance
//   o_pc, o_retire       current PC; one-cycle pulse per completed instruction
//   o_flags              {N,Z}
//
// state  | meaning
// FETCH  | instruction read request at PC
// WAIT_I | waiting for instruction word
// EXEC   | decode/execute; ALU and jumps retire here
// MEM    | ld/st request at Ry
// WAIT_D | waiting for ld data
module cpu_mc #(
  parameter int              DW       = 16,
  parameter int              AW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wrdata,
  input  logic          i_mem_waitrequest,
  input  logic [DW-1:0] i_mem_rddata,
  input  logic          i_mem_rddatavalid,
  output logic [AW-1:0] o_pc,
  output logic          o_retire,
  output logic [1:0]    o_flags
);

  typedef enum logic [2:0] {FETCH, WAIT_I, EXEC, MEM, WAIT_D} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [15:0]   ir;
  logic          ir_load;
  logic [DW-1:0] rf [8];
  logic          flag_n, flag_z, flag_we;
  logic [DW-1:0] flag_res;
  logic          rf_we;
  logic [2:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          retire;

  logic [3:0]    op;
  logic          imm_form;
  logic [2:0]    rx, ry;
  logic [DW-1:0] rx_val, ry_val, opb, imm8_sx, add_res, sub_res, mvhi_res;
  logic [AW-1:0] pc_inc, jofs, jtarget;
  logic          is_ld, is_st;

  assign op       = ir[3:0];
  assign imm_form = ir[4];
  assign rx       = ir[7:5];
  assign ry       = ir[10:8];
  assign rx_val   = rf[rx];
  assign ry_val   = rf[ry];
  assign imm8_sx  = DW'($signed(ir[15:8]));
  assign opb      = imm_form ? imm8_sx : ry_val;
  assign add_res  = rx_val + opb;
  assign sub_res  = rx_val - opb;
  assign is_ld    = (op == 4'd4) && !imm_form;
  assign is_st    = (op == 4'd5) && !imm_form;

  // imm11 is a halfword offset, so the sign-extended byte offset is imm11*2.
  assign jofs     = AW'($signed({ir[15:5], 1'b0}));
  assign pc_inc   = pc + AW'(2);
  assign jtarget  = imm_form ? (pc_inc + jofs) : {rx_val[AW-1:1], 1'b0};

  always_comb begin
    mvhi_res        = rx_val;
    mvhi_res[15:8]  = ir[15:8];
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_load   = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rx;
    rf_wdata  = '0;
    flag_we   = 1'b0;
    flag_res  = '0;
    retire    = 1'b0;
    case (state)
      FETCH: if (!i_mem_waitrequest) state_nxt = WAIT_I;
      WAIT_I: begin
        if (i_mem_rddatavalid) begin
          ir_load   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (is_ld || is_st) begin
          state_nxt = MEM;
        end else begin
          state_nxt = FETCH;
          retire    = 1'b1;
          pc_nxt    = pc_inc;
          case (op)
            4'd0: begin rf_we = 1'b1; rf_wdata = opb; end
            4'd1: begin rf_we = 1'b1; rf_wdata = add_res; flag_we = 1'b1; flag_res = add_res; end
            4'd2: begin rf_we = 1'b1; rf_wdata = sub_res; flag_we = 1'b1; flag_res = sub_res; end
            4'd3: begin flag_we = 1'b1; flag_res = sub_res; end
            4'd6: if (imm_form) begin rf_we = 1'b1; rf_wdata = mvhi_res; end
            4'd8: pc_nxt = jtarget;
            4'd9: if (flag_z) pc_nxt = jtarget;
            4'd10: if (flag_n) pc_nxt = jtarget;
            4'd12: begin
              // Target is computed from the pre-write register file, so
              // "call R7" jumps through the old R7.
              pc_nxt   = jtarget;
              rf_we    = 1'b1;
              rf_waddr = 3'd7;
              rf_wdata = DW'(pc_inc);
            end
            default: ;
          endcase
        end
      end
      MEM: begin
        if (!i_mem_waitrequest) begin
          if (is_st) begin
            retire    = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end else begin
            state_nxt = WAIT_D;
          end
        end
      end
      WAIT_D: begin
        if (i_mem_rddatavalid) begin
          rf_we     = 1'b1;
          rf_wdata  = i_mem_rddata;
          pc_nxt    = pc_inc;
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_load) ir <= i_mem_rddata[15:0];
      if (rf_we) rf[rf_waddr] <= rf_wdata;
      if (flag_we) begin
        flag_n <= flag_res[DW-1];
        flag_z <= (flag_res == '0);
      end
    end
  end

  // Bus strobes are gated by reset so an abandoned request drops immediately.
  assign o_mem_rd     = reset && ((state == FETCH) || ((state == MEM) && is_ld));
  assign o_mem_wr     = reset && (state == MEM) && is_st;
  assign o_mem_addr   = !reset          ? '0 :
                        (state == FETCH) ? pc :
                        (state == MEM)   ? ry_val[AW-1:0] : '0;
  assign o_mem_wrdata = (reset && (state == MEM) && is_st) ? rx_val : '0;
  assign o_retire     = reset && retire;
  assign o_pc         = pc;
  assign o_flags      = {flag_n, flag_z};

endmodule

// File: tb/tb_cpu_mc.sv
module tb_cpu_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_addr, mem_wrdata, rddata, pc;
  logic        mem_rd, mem_wr, waitreq, rdvalid, retire;
  logic [1:0]  flags;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:32767];
  int          wait_left = 0;
  int          data_lat = 1;
  int          lat_cnt = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] spur_addr = 16'hFFFF;
  logic        spur_pend = 1'b0;
  int          n_reads = 0;
  logic [15:0] last_waddr, last_wdata;

  cpu_mc #(.DW(16), .AW(16), .RESET_PC(16'h0010)) dut (
    .clk(clk), .reset(reset),
    .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_mem_wrdata(mem_wrdata),
    .i_mem_waitrequest(waitreq), .i_mem_rddata(rddata), .i_mem_rddatavalid(rdvalid),
    .o_pc(pc), .o_retire(retire), .o_flags(flags)
  );

  always #5 clk = ~clk;

  // Memory model: decides wait/accept and response for each cycle at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      lat_cnt = 0; rdvalid = 1'b0; waitreq = 1'b0; spur_pend = 1'b0; rddata = '0;
    end else begin
      rdvalid = 1'b0;
      rddata  = '0;
      if (spur_pend) begin
        rdvalid = 1'b1; rddata = 16'hFFFF; spur_pend = 1'b0;
      end
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          rdvalid = 1'b1;
          rddata  = mem[pend_addr[15:1]];
          if (pend_addr == spur_addr) spur_pend = 1'b1;
        end
      end
      waitreq = 1'b0;
      if (mem_rd || mem_wr) begin
        if (wait_left > 0) begin
          waitreq = 1'b1;
          wait_left--;
        end else if (mem_rd) begin
          n_reads++;
          pend_addr = mem_addr;
          lat_cnt   = (mem_addr >= 16'h0100) ? data_lat : 1;
        end else begin
          mem[mem_addr[15:1]] = mem_wrdata;
          last_waddr = mem_addr;
          last_wdata = mem_wrdata;
        end
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic i,
                                      input logic [2:0] rx, input logic [7:0] b);
    return {b, rx, i, op};
  endfunction

  function automatic logic [15:0] enc11(input logic [3:0] op, input logic [10:0] imm11);
    return {imm11, 1'b1, op};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0007;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    tick();
    tick();
    last_waddr = 16'h5555;
    last_wdata = 16'h5555;
    n_reads = 0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Returns the cycle (1-based, from the next sample) in which o_retire is seen.
  task automatic wait_retire(input int max, output int n);
    n = -1;
    for (int c = 1; c <= max && n < 0; c++) begin
      tick();
      if (retire === 1'b1) n = c;
    end
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL retire_timeout got=none exp=retire within %0d cycles", max);
    end
  endtask

  task automatic skip_retires(input int k);
    int n;
    for (int i = 0; i < k; i++) wait_retire(40, n);
  endtask

  task automatic test_reset();
    int n;
    fill_nop();
    mem[16'h10 >> 1] = enc(4'd0, 1'b1, 3'd1, 8'd5);
    mem[16'h12 >> 1] = enc(4'd5, 1'b0, 3'd1, 8'd2);
    reset = 1'b0;
    tick(); tick();
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_rd got=%0h exp=0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%0h exp=0", mem_wr); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_wrdata !== 16'h0) begin failures++; $display("FAIL rst_wrdata got=%h exp=0000", mem_wrdata); end
    checks++; if (retire !== 1'b0) begin failures++; $display("FAIL rst_retire got=%0h exp=0", retire); end
    checks++; if (flags !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", flags); end
    checks++; if (pc !== 16'h0010) begin failures++; $display("FAIL rst_pc got=%h exp=0010", pc); end
    release_reset();
    tick();
    checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL first_rd got=%0h exp=1", mem_rd); end
    checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL first_addr got=%h exp=0010", mem_addr); end
    wait_retire(20, n);
    checks++; if (n + 1 !== 3) begin failures++; $display("FAIL mv_cycles got=%0d exp=3", n + 1); end
    tick();
    checks++; if (pc !== 16'h0012) begin failures++; $display("FAIL mv_pc got=%h exp=0012", pc); end
    wait_retire(20, n);
    checks++; if (n + 1 !== 4) begin failures++; $display("FAIL st_cycles got=%0d exp=4", n + 1); end
    checks++; if (last_wdata !== 16'h0005) begin failures++; $display("FAIL mv_r1 got=%h exp=0005", last_wdata); end
    checks++; if (last_waddr !== 16'h0000) begin failures++; $display("FAIL st_addr_r2 got=%h exp=0000", last_waddr); end
  endtask

  task automatic test_branch();
    int n;
    // Z set: jz taken
    fill_nop();
    mem[16'h10 >> 1] = enc(4'd0, 1'b1, 3'd2, 8'd1);
    mem[16'h12 >> 1] = enc(4'd2, 1'b1, 3'd2, 8'd1);
    mem[16'h20 >> 1] = enc11(4'd9, 11'd3);
    mem[16'h28 >> 1] = enc(4'd5, 1'b0, 3'd2, 8'd0);
    release_reset();
    skip_retires(2);
    tick();
    checks++; if (flags !== 2'b01) begin failures++; $display("FAIL sub_flags_z got=%b exp=01", flags); end
    skip_retires(7);
    tick();
    checks++; if (pc !== 16'h0028) begin failures++; $display("FAIL jz_taken_pc got=%h exp=0028", pc); end
    wait_retire(20, n);
    checks++; if (last_wdata !== 16'h0000) begin failures++; $display("FAIL sub_r2 got=%h exp=0000", last_wdata); end
    // Z clear: jz falls through, then cmp/jn/mvhi
    fill_nop();
    mem[16'h10 >> 1] = enc(4'd0, 1'b1, 3'd2, 8'd2);
    mem[16'h12 >> 1] = enc(4'd2, 1'b1, 3'd2, 8'd1);
    mem[16'h20 >> 1] = enc11(4'd9, 11'd3);
    mem[16'h22 >> 1] = enc(4'd3, 1'b1, 3'd2, 8'd5);
    mem[16'h24 >> 1] = enc11(4'd10, 11'd2);
    mem[16'h2A >> 1] = enc(4'd6, 1'b1, 3'd2, 8'hAB);
    mem[16'h2C >> 1] = enc(4'd5, 1'b0, 3'd2, 8'd0);
    release_reset();
    skip_retires(2);
    tick();
    checks++; if (flags !== 2'b00) begin failures++; $display("FAIL sub_flags_nz got=%b exp=00", flags); end
    skip_retires(7);
    tick();
    checks++; if (pc !== 16'h0022) begin failures++; $display("FAIL jz_not_taken_pc got=%h exp=0022", pc); end
    wait_retire(20, n);
    tick();
    checks++; if (flags !== 2'b10) begin failures++; $display("FAIL cmp_flags got=%b exp=10", flags); end
    wait_retire(20, n);
    tick();
    checks++; if (pc !== 16'h002A) begin failures++; $display("FAIL jn_taken_pc got=%h exp=002a", pc); end
    skip_retires(2);
    checks++; if (last_wdata !== 16'hAB01) begin failures++; $display("FAIL mvhi_r2 got=%h exp=ab01", last_wdata); end
  endtask

  task automatic test_waitrequest();
    int n;
    int bad;
    fill_nop();
    mem[16'h10 >> 1] = enc(4'd0, 1'b1, 3'd1, 8'd5);
    wait_left = 4;
    release_reset();
    bad = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got rd=%0h addr=%h exp rd=1 addr=0010", c, mem_rd, mem_addr);
      end
    end
    wait_retire(20, n);
    checks++; if (n + 5 !== 7) begin failures++; $display("FAIL stall_retire_cycle got=%0d exp=7", n + 5); end
    checks++; if (n_reads !== 1) begin failures++; $display("FAIL stall_fetch_count got=%0d exp=1", n_reads); end
  endtask

  task automatic test_ld_st();
    int n;
    fill_nop();
    mem[16'h10 >> 1] = enc(4'd0, 1'b1, 3'd3, 8'hEF);
    mem[16'h12 >> 1] = enc(4'd6, 1'b1, 3'd3, 8'hBE);
    mem[16'h14 >> 1] = enc(4'd0, 1'b1, 3'd4, 8'h00);
    mem[16'h16 >> 1] = enc(4'd6, 1'b1, 3'd4, 8'h01);
    mem[16'h18 >> 1] = enc(4'd5, 1'b0, 3'd3, 8'd4);
    mem[16'h1A >> 1] = enc(4'd4, 1'b0, 3'd5, 8'd4);
    mem[16'h1C >> 1] = enc(4'd5, 1'b0, 3'd5, 8'd0);
    mem[16'h100 >> 1] = 16'h0000;
    data_lat = 3;
    release_reset();
    skip_retires(4);
    repeat (3) tick();
    tick();
    checks++; if (mem_wr !== 1'b1) begin failures++; $display("FAIL st_wr got=%0h exp=1", mem_wr); end
    checks++; if (mem_addr !== 16'h0100) begin failures++; $display("FAIL st_addr got=%h exp=0100", mem_addr); end
    checks++; if (mem_wrdata !== 16'hBEEF) begin failures++; $display("FAIL st_wrdata got=%h exp=beef", mem_wrdata); end
    checks++; if (retire !== 1'b1) begin failures++; $display("FAIL st_retire got=%0h exp=1", retire); end
    wait_retire(30, n);
    checks++; if (n !== 7) begin failures++; $display("FAIL ld_cycles got=%0d exp=7", n); end
    wait_retire(20, n);
    checks++; if (last_wdata !== 16'hBEEF) begin failures++; $display("FAIL ld_r5 got=%h exp=beef", last_wdata); end
    data_lat = 1;
  endtask

  task automatic test_call();
    int n;
    fill_nop();
    mem[16'h10 >> 1] = enc(4'd0, 1'b1, 3'd6, 8'h01);
    mem[16'h12 >> 1] = enc(4'd6, 1'b1, 3'd6, 8'h04);
    mem[16'h30 >> 1] = enc(4'd12, 1'b0, 3'd6, 8'd0);
    mem[16'h400 >> 1] = enc(4'd5, 1'b0, 3'd7, 8'd0);
    spur_addr = 16'h0030;
    release_reset();
    skip_retires(16);
    wait_retire(20, n);
    checks++; if (n !== 3) begin failures++; $display("FAIL call_cycles got=%0d exp=3", n); end
    tick();
    checks++; if (pc !== 16'h0400) begin failures++; $display("FAIL call_pc got=%h exp=0400", pc); end
    checks++; if (mem_addr !== 16'h0400 || mem_rd !== 1'b1) begin failures++; $display("FAIL call_fetch got rd=%0h addr=%h exp rd=1 addr=0400", mem_rd, mem_addr); end
    wait_retire(20, n);
    checks++; if (last_wdata !== 16'h0032) begin failures++; $display("FAIL call_r7 got=%h exp=0032", last_wdata); end
    spur_addr = 16'hFFFF;
  endtask

  task automatic test_reset_wait_d();
    int n;
    fill_nop();
    mem[16'h10 >> 1] = enc(4'd0, 1'b1, 3'd2, 8'h00);
    mem[16'h12 >> 1] = enc(4'd6, 1'b1, 3'd2, 8'h02);
    mem[16'h14 >> 1] = enc(4'd4, 1'b0, 3'd1, 8'd2);
    mem[16'h200 >> 1] = 16'h1234;
    data_lat = 5;
    release_reset();
    skip_retires(2);
    repeat (3) tick();
    tick();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin failures++; $display("FAIL ld_req got rd=%0h addr=%h exp rd=1 addr=0200", mem_rd, mem_addr); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin failures++; $display("FAIL abort_strobes got rd=%0h wr=%0h exp 0 0", mem_rd, mem_wr); end
    checks++; if (pc !== 16'h0010) begin failures++; $display("FAIL abort_pc got=%h exp=0010", pc); end
    mem[16'h10 >> 1] = enc(4'd5, 1'b0, 3'd1, 8'd2);
    data_lat = 1;
    release_reset();
    tick();
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin failures++; $display("FAIL refetch got rd=%0h addr=%h exp rd=1 addr=0010", mem_rd, mem_addr); end
    wait_retire(20, n);
    checks++; if (n + 1 !== 4) begin failures++; $display("FAIL refetch_st_cycles got=%0d exp=4", n + 1); end
    checks++; if (last_wdata !== 16'h0000 || last_waddr !== 16'h0000) begin failures++; $display("FAIL regs_cleared got data=%h addr=%h exp 0000 0000", last_wdata, last_waddr); end
  endtask

  initial begin
    waitreq = 1'b0;
    rdvalid = 1'b0;
    rddata  = '0;
    test_reset();
    test_branch();
    test_waitrequest();
    test_ld_st();
    test_call();
    test_reset_wait_d();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Parametrised multicycle successor to the team's non-pipelined 16-bit CPU.
- Same 8-register, 16-bit instruction format, generalised in data width and address width.
- Adds a stallable memory interface: waitrequest, plus a separate read-data-valid strobe.
- Adds retire/PC debug outputs for the bench.
- Sits between the instruction/data memory arbiter and the system bus; executes one instruction at a time.

Parameters:
- DW, 16, data/register width (≥16); instructions always occupy rddata[15:0].
- AW, 16, memory byte-address width (≤DW).
- RESET_PC, 0, PC value after reset (even).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- o_mem_addr  out  AW  byte address of current request.
- o_mem_rd  out  1  read request.
- o_mem_wr  out  1  write request.
- o_mem_wrdata  out  DW  store data.
- i_mem_waitrequest  in  1  1 = request not accepted this cycle.
- i_mem_rddata  in  DW  read data.
- i_mem_rddatavalid  in  1  i_mem_rddata valid this cycle.
- o_pc  out  AW  current PC.
- o_retire  out  1  one-cycle pulse when an instruction completes.
- o_flags  out  2  {N,Z}.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH; PC=RESET_PC; R0..R7=0; N=Z=0.
  - o_mem_rd=o_mem_wr=0; o_mem_addr=0; o_mem_wrdata=0; o_retire=0.
  - Any outstanding transaction is abandoned.
- Bus protocol:
  - At most one outstanding request.
  - rd/wr, addr and wrdata are held stable until a cycle with waitrequest=0; that cycle accepts the request.
  - Read data returns ≥1 cycle after acceptance, flagged by rddatavalid.
  - rddatavalid outside the WAIT states is ignored.
- FETCH: rd=1, addr=PC. On accept, go to WAIT_I.
- WAIT_I: rd=0. On rddatavalid, IR ← rddata[15:0], go to EXEC.
- EXEC (one cycle):
  - Decode and execute.
  - ALU/jump instructions: update registers, flags and PC, pulse o_retire, go to FETCH.
  - ld/st: go to MEM.
- MEM:
  - ld: rd=1, addr=Ry[AW-1:0].
  - st: wr=1, addr=Ry[AW-1:0], wrdata=Rx.
  - On accept: st pulses o_retire, sets PC+=2, goes to FETCH; ld goes to WAIT_D.
- WAIT_D: on rddatavalid, Rx ← rddata, PC+=2, pulse o_retire, go to FETCH.
- Minimum cycles with zero waits and 1-cycle read latency: ALU/jump 3, st 4, ld 5.
- Instruction format:
  - op=IR[3:0]; I=IR[4] (immediate form); Rx=IR[7:5]; Ry=IR[10:8].
  - imm8=IR[15:8], sign-extended to DW; imm11=IR[15:5], sign-extended.
  - Operand B = I ? sext(imm8) : Ry.
- Opcodes:
  - 0 mv: Rx←B.
  - 1 add: Rx←Rx+B.
  - 2 sub: Rx←Rx−B.
  - 3 cmp: flags only, from Rx−B.
  - 4 ld (I=0 only).
  - 5 st (I=0 only).
  - 6 mvhi (I=1 only): Rx←{imm8, Rx[7:0]} for DW=16; for DW>16, Rx[15:8]←imm8 and other bits kept.
  - 8 j, 9 jz (if Z), 10 jn (if N), 12 call (R7←PC+2, then jump).
- Jump target:
  - I=0: {Rx[AW-1:1],0}.
  - I=1: PC+2+2·sext(imm11).
  - Truncated to AW bits.
  - Jump not taken: PC+=2.
- Any other opcode/form combination is a NOP: PC+=2, retires normally.
- Arithmetic is modulo 2^DW; PC arithmetic is modulo 2^AW.
- Flags:
  - Only add/sub/cmp update them: Z = result==0; N = result[DW-1].
  - Flags set in EXEC are visible to the next instruction.
- call with Rx=R7, register form: target uses the old R7; R7 then receives PC+2.
- Writes to R0 are permitted (no hardwired zero).

Test Plan:
- Reset release, RESET_PC=0x0010, waitrequest=0, 1-cycle latency -> first cycle rd=1 addr=0x0010; o_retire after 3 cycles for "mv R1,#5"; R1=5.
- "sub R2,#1" with R2=1 -> R2=0, Z=1, N=0; next "jz #+3" at PC=0x20 -> o_pc=0x28; with Z=0 -> o_pc=0x22.
- waitrequest held 1 for 4 cycles during FETCH -> rd and addr stable all 5 cycles; exactly one fetch; retire delayed by 4 cycles.
- st R3→[R4] (R3=0xBEEF, R4=0x0100), then ld R5←[R4] with 3-cycle read latency -> wr=1 addr=0x0100 wrdata=0xBEEF; R5=0xBEEF; ld retires 7 cycles after its fetch.
- "call R6" with R6=0x0401 at PC=0x30 -> o_pc=0x0400, R7=0x0032; spurious rddatavalid in EXEC ignored.
- reset=0 asserted in WAIT_D -> rd/wr drop to 0 same cycle; after release, fetch at RESET_PC; R*=0.
